div_iter: RTL and testbench



---
 rtl/div_iter.sv | 207 ++++++++++++++++++++
 tb/tb_div_iter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
//
// Sequential radix-2 restoring integer divider for the execute stage. One
// divide is in flight at a time; it produces a quotient truncated toward zero
// and a remainder whose sign follows the dividend. Signed operands are
// reduced to magnitudes, divided unsigned over WIDTH iterations, and the
// signs are re-applied in a final fix-up cycle.
//
// Flow: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> DONE -> IDLE
//       A zero divisor short-cuts PREP -> DONE.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   start      in   request valid, accepted only while busy=0
//   x          in   dividend  [WIDTH-1:0]
//   y          in   divisor   [WIDTH-1:0]
//   sig        in   1 = signed (two's complement), 0 = unsigned
//   flush      in   abort the current operation, return to IDLE
//   busy       out  1 whenever the divider is not IDLE
//   out_valid  out  quotient/remainder valid
//   out_ready  in   consumer accepts the result
//   quotient   out  quotient  [WIDTH-1:0]
//   remainder  out  remainder [WIDTH-1:0]
// ---------------------------------------------------------------------------
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sig,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Control state (asynchronously reset)
  logic [2:0]       r_state;
  logic             r_busy;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;

  // Datapath state (no reset; always written before it is read)
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_sig;
  logic [WIDTH-1:0] r_dvd;     // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0] r_dvs;     // divisor magnitude
  logic [WIDTH-1:0] r_prem;    // partial remainder
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_y_zero;

  // Two's complement negation, wrapping at WIDTH bits.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Magnitude of v when interpreted as signed; raw value otherwise.
  // The most negative value maps onto itself, which is its correct
  // unsigned magnitude (2^(WIDTH-1)).
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v,
                                             input logic             s);
    return (s && v[WIDTH-1]) ? f_neg(v) : v;
  endfunction

  // Conditionally negate for the sign fix-up.
  function automatic logic [WIDTH-1:0] f_apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             n);
    return n ? f_neg(v) : v;
  endfunction

  // The shifted partial remainder needs WIDTH+1 bits for the trial compare.
  // The stored remainder is always below the divisor magnitude, so a
  // successful subtraction always fits back into WIDTH bits and the
  // difference can be formed modulo 2^WIDTH.
  assign w_shift  = {r_prem, r_dvd[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_diff   = w_shift[WIDTH-1:0] - r_dvs;
  assign w_q_fix  = f_apply_sign(r_dvd, r_neg_q);
  assign w_r_fix  = f_apply_sign(r_prem, r_neg_r);
  assign w_y_zero = (r_y == '0);

  // Control FSM. flush overrides every transition, including the DONE
  // handshake; the result registers keep stale values on flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_quot      <= '0;
      r_rem_out   <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_PREP;
            r_busy  <= 1'b1;
          end
        end
        S_PREP: begin
          if (w_y_zero) begin
            // Division by zero: all-ones quotient, untouched dividend.
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_quot      <= '1;
            r_rem_out   <= r_x;
          end else begin
            r_state <= S_ITER;
            r_cnt   <= CNT_LOAD;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_quot      <= w_q_fix;
          r_rem_out   <= w_r_fix;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Datapath. Operands are captured on any IDLE start; if flush drops the
  // request the captured values are simply never used.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (start) begin
          r_x   <= x;
          r_y   <= y;
          r_sig <= sig;
        end
      end
      S_PREP: begin
        r_dvd   <= f_mag(r_x, r_sig);
        r_dvs   <= f_mag(r_y, r_sig);
        r_prem  <= '0;
        r_neg_q <= r_sig & (r_x[WIDTH-1] ^ r_y[WIDTH-1]);
        r_neg_r <= r_sig & r_x[WIDTH-1];
      end
      S_ITER: begin
        // Restoring step: keep the difference only when it is non-negative,
        // and shift the resulting quotient bit into the vacated dividend LSB.
        r_prem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_dvd  <= {r_dvd[WIDTH-2:0], w_ge};
      end
      default: begin
      end
    endcase
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_rem_out;

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         sig = 1'b0;
  logic         flush = 1'b0;
  logic         busy;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  always #5 clk = ~clk;

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .sig       (sig),
    .flush     (flush),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  typedef struct {
    logic [31:0] vx;
    logic [31:0] vy;
    logic        vs;
    logic [31:0] eq;
    logic [31:0] er;
    int          elat;   // clock edges from the accepting edge to out_valid
  } vec_t;

  vec_t vecs[12];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    x = a; y = b; sig = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until out_valid, bounded so a dead DUT cannot hang the run.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] hq, hr;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34};
    vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34};
    vecs[2]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'h0000_0000,  34};
    vecs[3]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'h0000_0000,  34};
    vecs[4]  = '{32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678,  1};
    vecs[5]  = '{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          34};
    vecs[6]  = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          34};
    vecs[7]  = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  34};
    vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  34};
    vecs[9]  = '{32'h8000_0001,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  1};
    vecs[10] = '{32'd1000000,    32'd3,          1'b0, 32'h0005_1615,  32'd1,          34};
    vecs[11] = '{32'hFFFF_FFFF,  32'h0001_0000,  1'b0, 32'h0000_FFFF,  32'h0000_FFFF,  34};

    // Reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q",     quotient,           32'd0);
    chk("rst_r",     remainder,          32'd0);
    #9 rst = 1'b1;

    // Table-driven vectors with out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].vx, vecs[i].vy, vecs[i].vs);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_valid(lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].elat);
      chk($sformatf("v%0d_q", i), quotient, vecs[i].eq);
      chk($sformatf("v%0d_r", i), remainder, vecs[i].er);
      @(posedge clk); #1;
      chk($sformatf("v%0d_vld_off", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // Backpressure: hold the result for 5 cycles, ignore a start meanwhile
    out_ready = 1'b0;
    issue(32'd100, 32'd7, 1'b0);
    wait_valid(lat);
    chk("bp_lat", lat, 34);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        x = 32'd50; y = 32'd5; sig = 1'b0; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("bp%0d_vld", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_q", k), quotient, 32'd14);
      chk($sformatf("bp%0d_r", k), remainder, 32'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_vld_off", {31'd0, out_valid}, 32'd0);
    chk("bp_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_queue", {31'd0, busy}, 32'd0);

    // Flush in ITER at T+10, then a fresh divide completes normally
    issue(32'd1000, 32'd3, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_vld", {31'd0, out_valid}, 32'd0);
    issue(32'd100, 32'd7, 1'b0);
    wait_valid(lat);
    chk("fl_new_lat", lat, 34);
    chk("fl_new_q", quotient, 32'd14);
    chk("fl_new_r", remainder, 32'd2);
    @(posedge clk); #1;

    // start and flush together in IDLE: request dropped
    @(posedge clk); #1;
    x = 32'd9; y = 32'd3; sig = 1'b0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("sf_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sf_still_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-ITER (result regs hold 14 before this)
    issue(32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_busy",  {31'd0, busy},      32'd0);
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_q",     quotient,           32'd0);
    chk("ar_r",     remainder,          32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("ar_idle", {31'd0, busy}, 32'd0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_valid(lat);
    chk("ar_new_lat", lat, 34);
    chk("ar_new_q", quotient, 32'hFFFF_FFFD);
    chk("ar_new_r", remainder, 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
